// File: rtl/stopwatch_controller.sv
// Stopwatch run-control: button synchronise/debounce, start/stop/lap/reset FSM,
// 1 Hz count-enable prescaler and lap snapshot for the display.
module stopwatch_controller #(
    parameter int TICK_DIVISOR    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop_button,
    input  logic       lap_reset_button,
    input  logic [6:0] minutes,
    input  logic [6:0] seconds,
    output logic       count_tick,
    output logic       count_clear,
    output logic       running,
    output logic       lap_active,
    output logic [6:0] display_minutes,
    output logic [6:0] display_seconds
);
    localparam int PW = $clog2(TICK_DIVISOR);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]           level_q, level_d, press_q, press_d;
    logic [1:0][DW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [6:0]           lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
    logic                 tick_q, tick_d, clear_q, clear_d;
    logic                 running_q, running_d, lap_active_q, lap_active_d;
    logic                 ss_press, lr_press, run_now, run_next;

    // Index 0 is start/stop, index 1 is lap/reset.
    always_comb begin
        sync1_d = {lap_reset_button, start_stop_button};
        sync2_d = sync1_q;
        for (int b = 0; b < 2; b++) begin
            level_d[b] = level_q[b];
            cnt_d[b]   = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1))
                    level_d[b] = ~level_q[b];
                else
                    cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    assign ss_press = press_q[0];
    assign lr_press = press_q[1];

    always_comb begin
        state_d   = state_q;
        clear_d   = 1'b0;
        lap_min_d = lap_min_q;
        lap_sec_d = lap_sec_q;
        case (state_q)
            IDLE: begin
                if (ss_press)      state_d = RUN;
                else if (lr_press) clear_d = 1'b1;
            end
            RUN: begin
                if (ss_press) state_d = PAUSE;
                else if (lr_press) begin
                    state_d   = LAP;
                    lap_min_d = minutes;
                    lap_sec_d = seconds;
                end
            end
            LAP: begin
                if (ss_press)      state_d = PAUSE;
                else if (lr_press) state_d = RUN;
            end
            PAUSE: begin
                if (ss_press) state_d = RUN;
                else if (lr_press) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        run_now  = (state_q == RUN) || (state_q == LAP);
        run_next = (state_d == RUN) || (state_d == LAP);

        // Only edges that stay in a running state advance time, so no tick can
        // land in the first cycle of PAUSE/IDLE.
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clear_d)
            presc_d = '0;
        else if (run_now && run_next) begin
            if (presc_q == PW'(TICK_DIVISOR - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else
                presc_d = presc_q + 1'b1;
        end

        running_d    = run_next;
        lap_active_d = (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            press_q      <= '0;
            cnt_q        <= '0;
            presc_q      <= '0;
            lap_min_q    <= '0;
            lap_sec_q    <= '0;
            tick_q       <= 1'b0;
            clear_q      <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
            presc_q      <= presc_d;
            lap_min_q    <= lap_min_d;
            lap_sec_q    <= lap_sec_d;
            tick_q       <= tick_d;
            clear_q      <= clear_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign count_tick      = tick_q;
    assign count_clear     = clear_q;
    assign running         = running_q;
    assign lap_active      = lap_active_q;
    assign display_minutes = lap_active_q ? lap_min_q : minutes;
    assign display_seconds = lap_active_q ? lap_sec_q : seconds;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: per-cycle behavioural model, tick/clear
// scoreboard queues, a table of press/display vectors and corner sequences.
module tb_stopwatch_controller;
    localparam int TD = 10;
    localparam int DB = 4;
    localparam int LAT = 7;  // button edge to registered state change

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop_button = 1'b0;
    logic       lap_reset_button = 1'b0;
    logic [6:0] minutes = '0;
    logic [6:0] seconds = '0;
    logic       count_tick, count_clear, running, lap_active;
    logic [6:0] display_minutes, display_seconds;

    stopwatch_controller #(.TICK_DIVISOR(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset),
        .start_stop_button(start_stop_button), .lap_reset_button(lap_reset_button),
        .minutes(minutes), .seconds(seconds),
        .count_tick(count_tick), .count_clear(count_clear),
        .running(running), .lap_active(lap_active),
        .display_minutes(display_minutes), .display_seconds(display_seconds)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mstate_t;
    typedef struct {
        logic ss; logic lr; int mi; int se;
        logic e_run; logic e_lap; int e_dm; int e_ds;
    } vec_t;

    int      n_checks = 0, n_fail = 0;
    int      cyc = 0, ss_at = -1, lr_at = -1;
    int      last_tick = -1, last_clr = -1;
    mstate_t m_state = M_IDLE;
    int      mp = 0, lap_m = 0, lap_s = 0;
    int      tick_sb[$], clr_sb[$];
    vec_t    tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic is_run(input mstate_t s);
        return (s == M_RUN) || (s == M_LAP);
    endfunction

    task automatic sb_check(input string name, input logic seen, inout int q[$],
                            output logic hit);
        int e;
        hit = 1'b0;
        if (seen) begin
            hit = 1'b1;
            if (q.size() == 0) chk({name, "_unexpected"}, 1, 0);
            else begin
                e = q.pop_front();
                chk({name, "_cycle"}, cyc, e);
            end
        end else if (q.size() > 0 && q[0] <= cyc) begin
            e = q.pop_front();
            chk({name, "_missed"}, 0, 1);
        end
    endtask

    task automatic step();
        logic ssp, lrp, et, ec, hit;
        mstate_t nxt;
        @(posedge clk); #1; cyc++;
        et = 1'b0; ec = 1'b0;
        if (reset) begin
            m_state = M_IDLE; mp = 0; lap_m = 0; lap_s = 0;
        end else begin
            ssp = (cyc == ss_at); lrp = (cyc == lr_at);
            nxt = m_state;
            case (m_state)
                M_IDLE:  if (ssp) nxt = M_RUN; else if (lrp) ec = 1'b1;
                M_RUN:   if (ssp) nxt = M_PAUSE;
                         else if (lrp) begin nxt = M_LAP; lap_m = minutes; lap_s = seconds; end
                M_LAP:   if (ssp) nxt = M_PAUSE; else if (lrp) nxt = M_RUN;
                default: if (ssp) nxt = M_RUN; else if (lrp) begin nxt = M_IDLE; ec = 1'b1; end
            endcase
            if (ec) mp = 0;
            else if (is_run(m_state) && is_run(nxt)) begin
                if (mp == TD - 1) begin mp = 0; et = 1'b1; end
                else mp++;
            end
            m_state = nxt;
        end
        if (et) tick_sb.push_back(cyc);
        if (ec) clr_sb.push_back(cyc);
        sb_check("tick", count_tick, tick_sb, hit);
        if (hit) last_tick = cyc;
        sb_check("clear", count_clear, clr_sb, hit);
        if (hit) last_clr = cyc;
        chk("tick_clear_excl", int'(count_tick & count_clear), 0);
        chk("running", int'(running), int'(is_run(m_state)));
        chk("lap_active", int'(lap_active), int'(m_state == M_LAP));
        chk("disp_min", int'(display_minutes), (m_state == M_LAP) ? lap_m : int'(minutes));
        chk("disp_sec", int'(display_seconds), (m_state == M_LAP) ? lap_s : int'(seconds));
    endtask

    // Hold the button(s) 8 cycles, release 8 cycles so the level settles back.
    task automatic press(input logic ss, input logic lr);
        ss_at = ss ? cyc + LAT : -1;
        lr_at = lr ? cyc + LAT : -1;
        start_stop_button = ss; lap_reset_button = lr;
        repeat (8) step();
        start_stop_button = 1'b0; lap_reset_button = 1'b0;
        repeat (8) step();
    endtask

    task automatic wait_tick(input int lim);
        for (int i = 0; i < lim; i++) begin
            step();
            if (count_tick) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    initial begin
        int r, t;
        tbl[0] = '{1'b1, 1'b0, 3, 42, 1'b1, 1'b0, 3, 42};
        tbl[1] = '{1'b0, 1'b1, 3, 42, 1'b1, 1'b1, 3, 42};
        tbl[2] = '{1'b0, 1'b0, 3, 45, 1'b1, 1'b1, 3, 42};
        tbl[3] = '{1'b0, 1'b1, 3, 45, 1'b1, 1'b0, 3, 45};
        tbl[4] = '{1'b0, 1'b1, 5, 10, 1'b1, 1'b1, 5, 10};
        tbl[5] = '{1'b1, 1'b0, 5, 20, 1'b0, 1'b0, 5, 20};
        tbl[6] = '{1'b1, 1'b0, 6,  0, 1'b1, 1'b0, 6,  0};
        tbl[7] = '{1'b1, 1'b1, 6,  1, 1'b0, 1'b0, 6,  1};
        tbl[8] = '{1'b0, 1'b1, 6,  2, 1'b0, 1'b0, 6,  2};

        repeat (3) step();
        chk("reset_running", int'(running), 0);
        chk("reset_tick", int'(count_tick), 0);
        chk("reset_clear", int'(count_clear), 0);
        reset = 1'b0;
        repeat (2) step();

        // Bouncing button: never stable long enough to register.
        for (int i = 0; i < 15; i++) begin
            start_stop_button = ~start_stop_button;
            repeat (2) step();
        end
        start_stop_button = 1'b0;
        repeat (8) step();
        chk("bounce_idle", int'(running), 0);

        // Start, then tick cadence.
        r = cyc + LAT;
        press(1'b1, 1'b0);
        wait_tick(30);
        chk("first_tick_delay", cyc - r, TD);
        t = cyc;
        wait_tick(30);
        chk("tick_period", cyc - t, TD);

        // Pause with 3 cycles of prescale accumulated, resume, then clear.
        repeat (7) step();
        press(1'b1, 1'b0);
        chk("paused", int'(running), 0);
        repeat (20) step();
        r = cyc + LAT;
        press(1'b1, 1'b0);
        chk("resume_tick_delay", last_tick - r, TD - 3);
        press(1'b1, 1'b0);
        t = cyc + LAT;
        press(1'b0, 1'b1);
        chk("pause_clear_cycle", last_clr, t);
        chk("cleared_idle", int'(running), 0);

        // Lap freeze / release, simultaneous presses, clear from PAUSE.
        for (int i = 0; i < 9; i++) begin
            minutes = 7'(tbl[i].mi);
            seconds = 7'(tbl[i].se);
            press(tbl[i].ss, tbl[i].lr);
            chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].e_run));
            chk($sformatf("vec%0d_lap", i), int'(lap_active), int'(tbl[i].e_lap));
            chk($sformatf("vec%0d_dmin", i), int'(display_minutes), tbl[i].e_dm);
            chk($sformatf("vec%0d_dsec", i), int'(display_seconds), tbl[i].e_ds);
        end

        // Reset in LAP with a tick one cycle away.
        minutes = 7'd12; seconds = 7'd34;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("lap_before_reset", int'(lap_active), 1);
        wait_tick(30);
        repeat (8) step();
        minutes = '0; seconds = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_running", int'(running), 0);
        chk("rst_lap", int'(lap_active), 0);
        chk("rst_tick", int'(count_tick), 0);
        chk("rst_clear", int'(count_clear), 0);
        chk("rst_dmin", int'(display_minutes), 0);
        chk("rst_dsec", int'(display_seconds), 0);
        t = last_tick;
        repeat (15) step();
        chk("no_tick_after_reset", last_tick, t);

        chk("tick_sb_empty", tick_sb.size(), 0);
        chk("clear_sb_empty", clr_sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1);
    end

endmodule
